qnigma_mdio_responder: RTL
==========================

Name: qnigma_mdio_responder

Overview:
- MDIO management responder (PHY-side end of the Clause 22 MDIO link).
- Oversamples MDC/MDIO on the system clock, decodes management frames addressed to its PHY address, and converts them into single-cycle register-file read/write strobes.
- For read frames it drives turnaround and data back to the station.
- Used as a PHY model in system benches and as a management target in FPGA-to-FPGA links.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PREAMBLE_MIN, 32, minimum consecutive sampled ones before a start bit is accepted; legal range 1..32.
- SYNC_STAGES, 2, synchroniser depth for mdc and mdi; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mdc  in  1  management clock from the station, asynchronous to clk.
- mdi  in  1  MDIO line as seen by the responder.
- mdo  out  1  MDIO value driven by the responder.
- mdt  out  1  output enable; 1 = responder drives the line.
- reg_adr  out  5  register address of the current access.
- reg_wr  out  1  one-clk write strobe.
- reg_wdat  out  16  write data, valid with reg_wr.
- reg_rd  out  1  one-clk read strobe.
- reg_rdat  in  16  read data; must be valid 2 clk after reg_rd.
- frame_err  out  1  one-clk pulse on a protocol violation.

Behaviour:
- Clock and reset: single clock domain clk. rst is synchronous and active-high.
- Reset values: all outputs 0; state PREAMBLE; preamble counter 0.
- Synchronisation and edges:
  - mdc and mdi each pass through SYNC_STAGES flops.
  - A registered copy of the synchronised mdc gives rise and fall pulses.
  - Bits are sampled on rise. The responder changes mdo/mdt only on fall.
  - Pin-to-action latency is SYNC_STAGES+1 clk.
- Timing constraint: MDC half-period ≥ SYNC_STAGES+4 clk.
- Frame format, MSB first: preamble of ones, start 01, op (10 = read, 01 = write), phyad[4:0], regad[4:0], TA (2 bits), data[15:0].
- State machine; all transitions happen on rise:
  - PREAMBLE:
    - Bit 1: count saturating at 32.
    - Bit 0 with count ≥ PREAMBLE_MIN: go to START. This 0 is the first start bit.
    - Bit 0 with count < PREAMBLE_MIN: clear count, stay.
  - START: bit 1 goes to OP. Bit 0 sets frame_err and goes to PREAMBLE with count 0.
  - OP:
    - Shift 2 bits; latch read/write.
    - 00 or 11: frame_err, go to PREAMBLE with count 0.
  - PHYAD: 5 bits. No match goes to SKIP; match goes to REGAD.
  - REGAD:
    - 5 bits; reg_adr updates on the 5th bit.
    - Read: reg_rd pulses 1 clk after the 5th bit, then go to TA.
    - Write: go to TA directly.
  - TA, read:
    - Line not driven on bit 1.
    - On the fall after TA bit 1: mdt=1, mdo=0.
    - reg_rdat is loaded into the shift register at this point.
  - TA, write: expect bits 1,0. Mismatch sets frame_err and goes to SKIP with 16 bits remaining.
  - DATA, read:
    - mdo = shift[15], shifting on each fall after TA for 16 falls; mdi is ignored.
    - On the fall following the 16th data rise: mdt=0, mdo=0, go to PREAMBLE with count 0.
  - DATA, write:
    - Shift in 16 bits.
    - After the 16th: reg_wdat updates, reg_wr pulses the next clk, go to PREAMBLE with count 0.
  - SKIP: consume the remaining frame bits (2 TA + 16 data), never drive, then go to PREAMBLE with count 0.
- reg_rd and reg_wr are never both 1; each fires at most once per frame.
- rst mid-frame: mdt=0 and mdo=0 on the next clk; no strobe is emitted; state PREAMBLE with count 0.
- mdc static (station idle): state holds indefinitely.

Optional Feature:
- Macro: QNIGMA_MDIO_BCAST_EN.
- Defined: phyad 0 is accepted as broadcast for write frames only. Broadcast reads go to SKIP, with no reg_rd and no drive.
- Undefined: only PHY_ADDR matches; phyad 0 is treated like any other mismatch.

Test Plan:
- Write frame: 32 ones, 01, 01, phyad 1, regad 0x04, TA 10, data 0xA5C3 → one reg_wr pulse with reg_adr=4, reg_wdat=0xA5C3; mdt 0 throughout; frame_err 0.
- Read frame to regad 0x02 with reg_rdat=0x1234 returned 2 clk after reg_rd → one reg_rd; mdt=1 for 17 MDC bit periods starting at TA bit 2; sampled mdo is 0 followed by 0x1234 MSB first; mdt=0 after the last bit.
- Address mismatch: read to phyad 3 → no strobes, mdt 0. A back-to-back valid write follows → accepted normally.
- Short preamble of 20 ones then a write → ignored, no reg_wr. Op 11 after a valid preamble → frame_err pulse, no strobes.
- Write with TA 11 → frame_err pulse, no reg_wr. rst asserted mid read-data → mdt=0 the next clk, and the next frame is decoded correctly.
- With QNIGMA_MDIO_BCAST_EN: write to phyad 0, data 0x00FF → reg_wr with reg_wdat=0x00FF; read to phyad 0 → no reg_rd, mdt 0. Without the macro: the same write produces no reg_wr.

Source files
------------

// File: rtl/qnigma_mdio_responder.sv
// qnigma_mdio_responder
// PHY-side Clause 22 MDIO responder. MDC and MDIO are oversampled on clk and
// decoded into single-cycle register-file read/write strobes. For read frames
// the responder drives the TA bit and the 16 data bits back to the station.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   mdc, mdi        management clock and MDIO line (asynchronous to clk)
//   mdo, mdt        MDIO drive value and drive enable (1 = drive)
//   reg_adr         register address of the current access
//   reg_wr/reg_wdat one-clk write strobe and its data
//   reg_rd/reg_rdat one-clk read strobe; reg_rdat valid 2 clk after reg_rd
//   frame_err       one-clk pulse on a protocol violation
//
// Optional feature: define QNIGMA_MDIO_BCAST_EN to accept phyad 0 as a
// broadcast address for write frames (broadcast reads are skipped).
//
// state    | meaning
// PREAMBLE | counting ones, waiting for the first start bit
// START    | expecting second start bit (1)
// OP       | shifting the 2 opcode bits
// PHYAD    | shifting the 5 PHY address bits
// REGAD    | shifting the 5 register address bits
// TA       | turnaround (read: release then drive 0; write: expect 10)
// DATA     | 16 data bits (read: drive out; write: shift in)
// SKIP     | consume remaining bits of a frame not for us
module qnigma_mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_MIN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdt,
  output logic [4:0]  reg_adr,
  output logic        reg_wr,
  output logic [15:0] reg_wdat,
  output logic        reg_rd,
  input  logic [15:0] reg_rdat,
  output logic        frame_err
);

  localparam logic [2:0] ST_PRE   = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_OP    = 3'd2;
  localparam logic [2:0] ST_PHYAD = 3'd3;
  localparam logic [2:0] ST_REGAD = 3'd4;
  localparam logic [2:0] ST_TA    = 3'd5;
  localparam logic [2:0] ST_DATA  = 3'd6;
  localparam logic [2:0] ST_SKIP  = 3'd7;

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdi_sync;
  logic                   mdc_q;
  logic                   rise;
  logic                   fall;
  logic                   bit_in;

  logic [2:0]  state;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;   // bits seen in a field; in SKIP, bits remaining
  logic [14:0] sh_in;
  logic [15:0] sh_out;
  logic        is_read;
  logic        ta_first;
  logic        rd_pend;
  logic        wr_pend;
  logic [4:0]  phy_in;
  logic        phy_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_sync <= '0;
      mdi_sync <= '0;
      mdc_q    <= 1'b0;
    end else begin
      mdc_sync <= {mdc_sync[SYNC_STAGES-2:0], mdc};
      mdi_sync <= {mdi_sync[SYNC_STAGES-2:0], mdi};
      mdc_q    <= mdc_sync[SYNC_STAGES-1];
    end
  end

  assign rise   = mdc_sync[SYNC_STAGES-1] & ~mdc_q;
  assign fall   = ~mdc_sync[SYNC_STAGES-1] & mdc_q;
  assign bit_in = mdi_sync[SYNC_STAGES-1];
  assign phy_in = {sh_in[3:0], bit_in};

`ifdef QNIGMA_MDIO_BCAST_EN
  assign phy_hit = (phy_in == PHY_ADDR) || ((phy_in == 5'd0) && !is_read);
`else
  assign phy_hit = (phy_in == PHY_ADDR);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PRE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      sh_in     <= '0;
      sh_out    <= '0;
      is_read   <= 1'b0;
      ta_first  <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      mdo       <= 1'b0;
      mdt       <= 1'b0;
      reg_adr   <= '0;
      reg_wr    <= 1'b0;
      reg_wdat  <= '0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      reg_rd    <= rd_pend;
      reg_wr    <= wr_pend;

      if (rise) begin
        case (state)
          ST_PRE: begin
            if (bit_in) begin
              if (pre_cnt < 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else if (pre_cnt >= PRE_MIN) begin
              state   <= ST_START;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          ST_START: begin
            if (bit_in) begin
              state   <= ST_OP;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_PRE;
              pre_cnt   <= '0;
            end
          end
          ST_OP: begin
            sh_in <= {sh_in[13:0], bit_in};
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              if ({sh_in[0], bit_in} == 2'b10) begin
                is_read <= 1'b1;
                state   <= ST_PHYAD;
              end else if ({sh_in[0], bit_in} == 2'b01) begin
                is_read <= 1'b0;
                state   <= ST_PHYAD;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_PRE;
                pre_cnt   <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_PHYAD: begin
            sh_in <= {sh_in[13:0], bit_in};
            if (bit_cnt == 5'd4) begin
              if (phy_hit) begin
                state   <= ST_REGAD;
                bit_cnt <= '0;
              end else begin
                // regad + TA + data still to come
                state   <= ST_SKIP;
                bit_cnt <= 5'd23;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_REGAD: begin
            sh_in <= {sh_in[13:0], bit_in};
            if (bit_cnt == 5'd4) begin
              reg_adr <= {sh_in[3:0], bit_in};
              rd_pend <= is_read;
              state   <= ST_TA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_TA: begin
            if (bit_cnt == 5'd0) begin
              ta_first <= bit_in;
              bit_cnt  <= 5'd1;
            end else if (is_read || ({ta_first, bit_in} == 2'b10)) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_SKIP;
              bit_cnt   <= 5'd16;
            end
          end
          ST_DATA: begin
            if (!is_read) begin
              sh_in <= {sh_in[13:0], bit_in};
              if (bit_cnt == 5'd15) begin
                reg_wdat <= {sh_in, bit_in};
                wr_pend  <= 1'b1;
                state    <= ST_PRE;
                pre_cnt  <= '0;
                bit_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else if (bit_cnt < 5'd16) begin
              // read frames leave DATA on the fall after the 16th rise
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: begin
            if (bit_cnt <= 5'd1) begin
              state   <= ST_PRE;
              pre_cnt <= '0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end
        endcase
      end else if (fall && is_read) begin
        if (state == ST_TA && bit_cnt == 5'd1) begin
          mdt    <= 1'b1;
          mdo    <= 1'b0;
          sh_out <= reg_rdat;
        end else if (state == ST_DATA) begin
          if (bit_cnt == 5'd16) begin
            mdt     <= 1'b0;
            mdo     <= 1'b0;
            state   <= ST_PRE;
            pre_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            mdo    <= sh_out[15];
            sh_out <= {sh_out[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
